fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 43 ++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and decode handshakes.
// master = fetch unit side, slave = memory / execute / decode side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned reads, tags the in-order
// responses with their request PC, and hands them to decode through a
// 2-entry buffer. Redirects flush the buffer and drain stale responses.
// At most two "tokens" (buffered entries + outstanding + to-be-dropped
// responses) exist at any time, so the buffer can never overflow.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  // architectural state
  logic [31:0] fetch_pc_reg;
  logic [31:0] buf_inst_reg [2];
  logic [31:0] buf_pc_reg [2];
  logic [1:0]  buf_count_reg;
  logic [31:0] pcq_reg [2];
  logic [1:0]  pend_count_reg;
  logic [1:0]  drop_count_reg;
  logic        resp_mask_reg;

  // next-state values for the non-redirect path
  logic [31:0] buf_inst_next [2];
  logic [31:0] buf_pc_next [2];
  logic [1:0]  buf_count_next;
  logic [31:0] pcq_next [2];
  logic [1:0]  pend_count_next;
  logic [1:0]  drop_count_next;

  logic       pop;
  logic       resp_live;
  logic       resp_drop;
  logic       push;
  logic       req_fire;
  logic       overflow;
  logic [2:0] budget;

  // Decode sees the registered head entry only.
  assign bus.inst_valid = (buf_count_reg != 2'd0);
  assign bus.inst       = buf_inst_reg[0];
  assign bus.inst_pc    = buf_pc_reg[0];

  assign pop = bus.inst_valid && bus.inst_ready;

  // Responses are ignored for one cycle after reset; the memory is reset too.
  assign resp_live = bus.imem_resp_valid && !resp_mask_reg;
  assign resp_drop = resp_live && (drop_count_reg != 2'd0);
  assign push      = resp_live && (drop_count_reg == 2'd0) && (pend_count_reg != 2'd0);

  // A head popped this cycle frees its slot immediately, which is what lets
  // a 1-cycle memory keep up with one instruction per cycle.
  assign budget = {1'b0, buf_count_reg} + {1'b0, pend_count_reg}
                + {1'b0, drop_count_reg} - {2'b00, pop};

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (budget < 3'd2);
  assign bus.imem_req_addr  = fetch_pc_reg;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Buffer update: shift out the popped head, then append the response.
  always_comb begin
    buf_inst_next  = buf_inst_reg;
    buf_pc_next    = buf_pc_reg;
    buf_count_next = buf_count_reg;
    if (pop) begin
      buf_inst_next[0] = buf_inst_reg[1];
      buf_pc_next[0]   = buf_pc_reg[1];
      buf_count_next   = buf_count_reg - 2'd1;
    end
    if (push && (buf_count_next != 2'd2)) begin
      buf_inst_next[buf_count_next[0]] = bus.imem_resp_data;
      buf_pc_next[buf_count_next[0]]   = pcq_reg[0];
      buf_count_next                   = buf_count_next + 2'd1;
    end
  end

  // PC tag queue: one entry per live outstanding request, oldest first.
  always_comb begin
    pcq_next        = pcq_reg;
    pend_count_next = pend_count_reg;
    if (push) begin
      pcq_next[0]     = pcq_reg[1];
      pend_count_next = pend_count_reg - 2'd1;
    end
    if (req_fire && (pend_count_next != 2'd2)) begin
      pcq_next[pend_count_next[0]] = fetch_pc_reg;
      pend_count_next              = pend_count_next + 2'd1;
    end
  end

  // Drop counter: a redirect turns everything still in flight into stale
  // responses, minus the one that arrives (and is discarded) that same cycle.
  always_comb begin
    drop_count_next = drop_count_reg;
    if (bus.redirect_valid) begin
      drop_count_next = drop_count_reg + pend_count_reg + {1'b0, req_fire}
                      - {1'b0, resp_live && ((drop_count_reg != 2'd0) || (pend_count_reg != 2'd0))};
    end else if (resp_drop) begin
      drop_count_next = drop_count_reg - 2'd1;
    end
  end

  // State register; redirect overrides any concurrent push/pop/request.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC & PC_MASK;
      buf_inst_reg[0] <= '0;
      buf_inst_reg[1] <= '0;
      buf_pc_reg[0]   <= '0;
      buf_pc_reg[1]   <= '0;
      buf_count_reg   <= 2'd0;
      pcq_reg[0]      <= '0;
      pcq_reg[1]      <= '0;
      pend_count_reg  <= 2'd0;
      drop_count_reg  <= 2'd0;
      resp_mask_reg   <= 1'b1;
    end else begin
      resp_mask_reg  <= 1'b0;
      drop_count_reg <= drop_count_next;
      if (bus.redirect_valid) begin
        fetch_pc_reg   <= bus.redirect_pc & PC_MASK;
        buf_count_reg  <= 2'd0;
        pend_count_reg <= 2'd0;
      end else begin
        if (req_fire) begin
          fetch_pc_reg <= fetch_pc_reg + 32'd4;
        end
        buf_inst_reg   <= buf_inst_next;
        buf_pc_reg     <= buf_pc_next;
        buf_count_reg  <= buf_count_next;
        pcq_reg        <= pcq_next;
        pend_count_reg <= pend_count_next;
      end
    end
  end

  // A live response with nowhere to go means the token budget was broken.
  assign overflow = resp_live && (drop_count_reg == 2'd0)
                 && ((pend_count_reg == 2'd0) || ((buf_count_reg == 2'd2) && !pop));

  assert property (@(posedge clk) disable iff (rst) !overflow);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency memory model, a program-
// order reference (expected decode PC / expected fetch address), directed
// scenarios with literal expectations and a randomized soak.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int consumed = 0;

  // stimulus knobs
  int          rdy_pct, mreq_pct, lat_min, lat_max;
  logic        rst_knob, redir_now, verbose, junk_prev, drv_from_mem;
  logic [31:0] redir_target, mem_xor;

  // memory model: in-order request queue with due cycles
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  // reference model
  logic [31:0] exp_pc, exp_fetch;
  logic [31:0] pop_log[$];
  logic        after_reset, after_redirect, prev_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare outputs for the current cycle, then advance the reference.
  task automatic evaluate();
    logic pop_now, hs_now;
    if (rst) begin
      if (prev_rst) check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
      check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
      mq_addr.delete();
      mq_due.delete();
      exp_pc = RESET_PC;
      exp_fetch = RESET_PC;
      after_reset = 1'b1;
      after_redirect = 1'b0;
      prev_rst = 1'b1;
      return;
    end
    prev_rst = 1'b0;
    if (after_reset) begin
      check("post_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      check("post_rst_addr", bus.imem_req_addr, RESET_PC);
      check("post_rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
      check("post_rst_inst", bus.inst, 32'd0);
      check("post_rst_inst_pc", bus.inst_pc, 32'd0);
    end
    if (after_redirect) check("flush_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    if (bus.redirect_valid) check("redirect_blocks_req", {31'b0, bus.imem_req_valid}, 32'd0);
    if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, exp_fetch);
    check("inflight_le_2", {31'b0, mq_addr.size() <= 2}, 32'd1);
    if (bus.inst_valid) begin
      check("inst_pc", bus.inst_pc, exp_pc);
      check("inst_data", bus.inst, exp_pc ^ mem_xor);
    end

    pop_now = bus.inst_valid && bus.inst_ready;
    hs_now  = bus.imem_req_valid && bus.imem_req_ready;
    if (drv_from_mem) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (hs_now) begin
      mq_addr.push_back(bus.imem_req_addr);
      mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (pop_now) begin
      pop_log.push_back(bus.inst_pc);
      consumed++;
      exp_pc = exp_pc + 32'd4;
      if (verbose) $display("[%0d] decode pc=%h inst=%h", cyc, bus.inst_pc, bus.inst);
    end
    if (bus.redirect_valid) begin
      exp_pc = bus.redirect_pc & PC_MASK;
      exp_fetch = bus.redirect_pc & PC_MASK;
      if (verbose) $display("[%0d] redirect to %h", cyc, bus.redirect_pc);
    end else if (hs_now) begin
      exp_fetch = exp_fetch + 32'd4;
    end
    after_reset = 1'b0;
    after_redirect = bus.redirect_valid;
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_knob;
    bus.inst_ready     = ($urandom_range(99) < rdy_pct);
    bus.imem_req_ready = ($urandom_range(99) < mreq_pct);
    bus.redirect_valid = redir_now;
    bus.redirect_pc    = redir_target;
    drv_from_mem = 1'b0;
    if (rst_knob || junk_prev) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
    end else if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mq_addr[0] ^ mem_xor;
      drv_from_mem = 1'b1;
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
    end
    junk_prev = rst_knob;
    @(negedge clk);
    evaluate();
  endtask

  task automatic do_reset();
    rst_knob = 1'b1;
    redir_now = 1'b0;
    step();
    step();
    rst_knob = 1'b0;
    pop_log.delete();
  endtask

  task automatic steady(input int lat);
    rdy_pct = 100; mreq_pct = 100; lat_min = lat; lat_max = lat;
  endtask

  initial begin
    int base;
    rst = 1'b1; rst_knob = 1'b0; redir_now = 1'b0; redir_target = 32'd0;
    verbose = 1'b1; junk_prev = 1'b0; drv_from_mem = 1'b0; mem_xor = 32'd0;
    prev_rst = 1'b0; after_reset = 1'b0; after_redirect = 1'b0;
    exp_pc = RESET_PC; exp_fetch = RESET_PC;
    bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'd0;

    // full-rate stream with a 1-cycle memory returning the address
    steady(1);
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step();
      if (c >= 2) begin
        check("t1_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("t1_pc", bus.inst_pc, 32'(4 * (c - 2)));
      end
    end
    check("t1_count", pop_log.size(), 32'd10);

    // decode stalled: two entries buffered, fetch stops, then in-order release
    steady(1);
    rdy_pct = 0;
    do_reset();
    repeat (5) step();
    check("t2_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("t2_inst_valid", {31'b0, bus.inst_valid}, 32'd1);
    check("t2_head_pc", bus.inst_pc, 32'd0);
    check("t2_no_outstanding", mq_addr.size(), 32'd0);
    rdy_pct = 100;
    repeat (6) step();
    check("t2_pop0", pop_log[0], 32'd0);
    check("t2_pop1", pop_log[1], 32'd4);
    check("t2_pop2", pop_log[2], 32'd8);

    // redirect with two requests in flight: both responses dropped
    steady(3);
    do_reset();
    repeat (2) step();
    check("t3_outstanding", mq_addr.size(), 32'd2);
    redir_now = 1'b1; redir_target = 32'h0000_1002;
    step();
    redir_now = 1'b0;
    repeat (10) step();
    check("t3_first_pc", pop_log[0], 32'h0000_1000);
    check("t3_second_pc", pop_log[1], 32'h0000_1004);

    // memory not ready for 3 cycles: address held, one increment
    steady(1);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      mreq_pct = (c < 3) ? 0 : 100;
      step();
      check("t4_addr", bus.imem_req_addr, (c < 4) ? 32'd0 : 32'd4);
    end

    // redirect coinciding with a pop and a response
    steady(1);
    do_reset();
    repeat (6) step();
    redir_now = 1'b1; redir_target = 32'h0000_2000;
    step();
    redir_now = 1'b0;
    check("t5_pop_here", {31'b0, bus.inst_valid && bus.inst_ready}, 32'd1);
    check("t5_resp_here", {31'b0, bus.imem_resp_valid}, 32'd1);
    check("t5_popped", pop_log.size(), 32'd5);
    step();
    check("t5_empty_after", {31'b0, bus.inst_valid}, 32'd0);
    repeat (6) step();
    check("t5_last_old", pop_log[4], 32'd16);
    check("t5_first_new", pop_log[5], 32'h0000_2000);

    // redirect to the last word: PC wraps to zero
    steady(1);
    do_reset();
    repeat (3) step();
    redir_now = 1'b1; redir_target = 32'hFFFF_FFFC;
    step();
    redir_now = 1'b0;
    repeat (8) step();
    check("t6_top", pop_log[2], 32'hFFFF_FFFC);
    check("t6_wrap0", pop_log[3], 32'h0000_0000);
    check("t6_wrap4", pop_log[4], 32'h0000_0004);

    // randomized soak with redirects and mid-flight resets
    verbose = 1'b0;
    mem_xor = 32'hA5C3_0F96;
    rdy_pct = 70; mreq_pct = 75; lat_min = 1; lat_max = 4;
    do_reset();
    base = consumed;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) < 3) begin
        do_reset();
        continue;
      end
      redir_now = !after_reset && ($urandom_range(99) < 3);
      if ($urandom_range(3) == 0) redir_target = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else redir_target = $urandom;
      step();
    end
    redir_now = 1'b0;
    check("random_progress", {31'b0, (consumed - base) > 300}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
